// File: rtl/key_load_ctrl.sv
// Cipher key loader: collects four 32-bit words into a shadow buffer, commits the full key,
// then times the round-key expansion. Optional readback port under macro KEY_LOAD_READBACK_EN.
module key_load_ctrl #(
  parameter int unsigned WIDTH       = 128,
  parameter int unsigned EXP_LATENCY = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [1:0]       wr_addr_i,
  input  logic [31:0]      wr_data_i,
  input  logic             clear_i,
  input  logic [1:0]       rd_addr_i,
  output logic [WIDTH-1:0] key_ciph_o,
  output logic             keys_ready_o,
  output logic             busy_o,
  output logic             wr_err_o,
  output logic [31:0]      rd_data_o
);

  localparam int unsigned CW = (EXP_LATENCY > 1) ? $clog2(EXP_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t          state_q, state_d;
  logic [3:0]      mask_q, mask_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // Index 0 is the most significant word, so the packed array is the key itself.
  logic [0:3][31:0] shadow_q, shadow_d;
  logic [0:3][31:0] key_q;
  logic            commit;
  logic            err_d, err_q;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    commit   = 1'b0;
    err_d    = 1'b0;
    if (clear_i) begin
      mask_d  = '0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (wr_en_i) begin
            shadow_d[wr_addr_i] = wr_data_i;
            mask_d = mask_q | (4'b0001 << wr_addr_i);
            if (mask_d == 4'b1111) begin
              commit  = 1'b1;
              mask_d  = '0;
              cnt_d   = CW'(EXP_LATENCY - 1);
              state_d = EXPAND;
            end
          end
        end
        EXPAND: begin
          err_d = wr_en_i;
          if (cnt_q == '0) state_d = READY;
          else             cnt_d   = cnt_q - CW'(1);
        end
        READY: begin
          if (wr_en_i) begin
            shadow_d[wr_addr_i] = wr_data_i;
            mask_d  = 4'b0001 << wr_addr_i;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      key_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      if (commit) key_q <= shadow_d;
    end
  end

  assign key_ciph_o   = WIDTH'(key_q);
  assign busy_o       = (state_q == EXPAND);
  assign keys_ready_o = (state_q == READY);
  assign wr_err_o     = err_q;

`ifdef KEY_LOAD_READBACK_EN
  logic [31:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) rd_q <= '0;
    else       rd_q <= key_q[rd_addr_i];
  end

  assign rd_data_o = rd_q;
`else
  logic unused_rd_addr;

  assign unused_rd_addr = ^rd_addr_i;
  assign rd_data_o      = '0;
`endif

endmodule
